// File: rtl/systolic_seq.sv
// Sequencer for the systolic NPU: loads weight rows, streams skewed activation rows, collects results.
// Optional abort support is compiled in with `define SEQ_ABORT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | reading weight rows 0..ARRAY_SIZE-1 from RAM
// STREAM | reading activation rows ACT_BASE+k, one per cycle
// DRAIN  | no reads; waiting for the result pipe to empty
module systolic_seq #(
  parameter int ARRAY_SIZE = 3,
  parameter int ACT_BASE   = 16,
  parameter int PIPE_LAT   = 5,
  parameter int AW         = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    n_rows,
  output logic          busy,
  output logic          done,
  output logic          ram_re,
  output logic [AW-1:0] ram_adr,
  input  logic [23:0]   ram_dat,
  output logic          arr_w_load,
  output logic [1:0]    arr_w_row,
  output logic [23:0]   arr_w_data,
  output logic          arr_en,
  output logic [23:0]   arr_a_data,
  input  logic [47:0]   arr_out,
  output logic          res_valid,
  output logic [47:0]   res_data,
  input  logic          abort
);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [7:0]    rem_q, rem_nxt;
  logic [7:0]    nrows_q, nrows_nxt;
  logic [AW-1:0] adr_q, adr_nxt;
  logic          rd_w, rd_a;
  logic          w_ld_q, act_iss_q;
  logic [1:0]    w_row_q;
  logic [PIPE_LAT-1:0] vpipe;
  logic [ARRAY_SIZE*8-1:0] lanes;
  logic          drain_done;
  logic          abort_hit;

  // Assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

`ifdef SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rem_q   <= '0;
      nrows_q <= '0;
      adr_q   <= '0;
    end else begin
      state   <= state_nxt;
      rem_q   <= rem_nxt;
      nrows_q <= nrows_nxt;
      adr_q   <= adr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_q;
    nrows_nxt = nrows_q;
    adr_nxt   = adr_q;
    ram_re    = 1'b0;
    rd_w      = 1'b0;
    rd_a      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_W;
          adr_nxt   = '0;
          rem_nxt   = 8'(ARRAY_SIZE - 1);
          nrows_nxt = n_rows;
        end
      end
      LOAD_W: begin
        ram_re = 1'b1;
        rd_w   = 1'b1;
        if (rem_q == '0) begin
          if (nrows_q == '0) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = STREAM;
            adr_nxt   = AW'(ACT_BASE);
            rem_nxt   = nrows_q - 8'd1;
          end
        end else begin
          adr_nxt = adr_q + AW'(1);
          rem_nxt = rem_q - 8'd1;
        end
      end
      STREAM: begin
        ram_re = 1'b1;
        rd_a   = 1'b1;
        if (rem_q == '0) begin
          state_nxt = DRAIN;
        end else begin
          adr_nxt = adr_q + AW'(1);
          rem_nxt = rem_q - 8'd1;
        end
      end
      DRAIN: begin
        if (drain_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ld_q    <= 1'b0;
      w_row_q   <= '0;
      act_iss_q <= 1'b0;
      vpipe     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (abort_hit) begin
      w_ld_q    <= 1'b0;
      act_iss_q <= 1'b0;
      vpipe     <= '0;
      res_valid <= 1'b0;
    end else begin
      w_ld_q    <= rd_w;
      w_row_q   <= adr_q[1:0];
      act_iss_q <= rd_a;
      vpipe     <= {vpipe[PIPE_LAT-2:0], act_iss_q};
      res_valid <= vpipe[PIPE_LAT-1];
      if (vpipe[PIPE_LAT-1]) res_data <= arr_out;
    end
  end

  // Lane g of an issued row reaches the array g cycles after lane 0.
  assign lanes[7:0] = act_iss_q ? ram_dat[7:0] : 8'd0;

  for (genvar g = 1; g < ARRAY_SIZE; g++) begin : g_skew
    logic [7:0] dly [g];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < g; j++) dly[j] <= '0;
      end else if (abort_hit) begin
        for (int j = 0; j < g; j++) dly[j] <= '0;
      end else begin
        dly[0] <= act_iss_q ? ram_dat[8*g +: 8] : 8'd0;
        for (int j = 1; j < g; j++) dly[j] <= dly[j-1];
      end
    end
    assign lanes[8*g +: 8] = dly[g-1];
  end

  assign drain_done = (state == DRAIN) && !w_ld_q && !act_iss_q && (vpipe == '0);
  assign done       = drain_done && !abort_hit;
  assign busy       = (state != IDLE);
  assign ram_adr    = ram_re ? adr_q : '0;
  assign arr_w_load = w_ld_q;
  assign arr_w_row  = w_ld_q ? w_row_q : 2'd0;
  assign arr_w_data = w_ld_q ? ram_dat : 24'd0;
  assign arr_en     = act_iss_q || (vpipe != '0);
  assign arr_a_data = arr_en ? lanes : 24'd0;

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq: RAM and array models, queued expectations checked by a monitor.
module tb_systolic_seq;
  localparam int AS = 3, AB = 16, PL = 5, AW = 9;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0]    n_rows = 8'd0;
  logic          busy, done, ram_re, arr_w_load, arr_en, res_valid;
  logic [AW-1:0] ram_adr;
  logic [23:0]   ram_dat, arr_w_data, arr_a_data;
  logic [1:0]    arr_w_row;
  logic [47:0]   arr_out, res_data;

  always #5 clk = ~clk;

  systolic_seq #(.ARRAY_SIZE(AS), .ACT_BASE(AB), .PIPE_LAT(PL), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n_rows(n_rows), .busy(busy), .done(done),
    .ram_re(ram_re), .ram_adr(ram_adr), .ram_dat(ram_dat), .arr_w_load(arr_w_load),
    .arr_w_row(arr_w_row), .arr_w_data(arr_w_data), .arr_en(arr_en), .arr_a_data(arr_a_data),
    .arr_out(arr_out), .res_valid(res_valid), .res_data(res_data), .abort(abort)
  );

  logic [23:0] mem  [0:511];
  logic [23:0] hist [0:7] = '{default: 24'd0};
  logic [23:0] wreg [0:3] = '{default: 24'd0};

  // Matrix-vector product: out lane j = sum_i a_i * W[i].byte_j, truncated to 16 bits.
  function automatic logic [47:0] mvm(input logic [23:0] a, input logic [23:0] w0,
                                      input logic [23:0] w1, input logic [23:0] w2);
    logic [23:0] w [0:2];
    logic [15:0] s;
    logic [47:0] r;
    w[0] = w0; w[1] = w1; w[2] = w2;
    r = '0;
    for (int j = 0; j < 3; j++) begin
      s = 16'd0;
      for (int i = 0; i < 3; i++) s = s + 16'(a[8*i +: 8]) * 16'(w[i][8*j +: 8]);
      r[16*j +: 16] = s;
    end
    return r;
  endfunction

  // RAM with one-cycle read latency (garbage when not read) and a de-skewing array model.
  always @(posedge clk) begin
    ram_dat <= ram_re ? mem[ram_adr] : 24'($urandom);
    for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= arr_a_data;
    if (arr_w_load) wreg[arr_w_row] <= arr_w_data;
  end
  assign arr_out = mvm({hist[2][23:16], hist[3][15:8], hist[4][7:0]}, wreg[0], wreg[1], wreg[2]);

  logic [AW-1:0] q_adr [$];
  logic [1:0]    q_wrow [$];
  logic [23:0]   q_w [$];
  logic [47:0]   q_res [$];
  int  n_cmp = 0, n_err = 0, ncyc = 0, rel = 0;
  int  job_t0 = 0, exp_done = 0, exp_n = 0;
  int  busy_cnt = 0, en_cnt = 0, rv_cnt = 0, gate_bad = 0;
  bit  job_active = 1'b0, job_done_seen = 1'b0, skew_chk = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] skew_exp(input int c);
    case (c)
      5: return 24'h000001;
      6: return 24'h000204;
      7: return 24'h030500;
      8: return 24'h060000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [127:0] all_outputs();
    return {busy, done, ram_re, ram_adr, arr_w_load, arr_w_row, arr_w_data,
            arr_en, arr_a_data, res_valid, res_data};
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (reset_n) begin
      rel = ncyc - job_t0;
      if (ram_re) begin
        if (q_adr.size() == 0) check("ram_re_unexpected", 1, 0);
        else check("ram_adr", ram_adr, q_adr.pop_front());
      end
      if (arr_w_load) begin
        if (q_w.size() == 0) check("w_load_unexpected", 1, 0);
        else begin
          check("w_row", arr_w_row, q_wrow.pop_front());
          check("w_data", arr_w_data, q_w.pop_front());
        end
      end
      if (!arr_en && arr_a_data != 24'd0) gate_bad++;
      if (skew_chk && job_active && rel >= 1 && rel <= 12) check("skew", arr_a_data, skew_exp(rel));
      if (job_active) begin
        if (busy) busy_cnt++;
        if (arr_en) en_cnt++;
      end
      if (res_valid) begin
        if (!job_active || q_res.size() == 0) check("res_valid_unexpected", 1, 0);
        else begin
          rv_cnt++;
          check("res_data", res_data, q_res.pop_front());
        end
      end
      if (done) begin
        if (!job_active) check("done_unexpected", 1, 0);
        else begin
          check("done_cycle", rel, exp_done);
          check("busy_cycles", busy_cnt, exp_done);
          check("arr_en_cycles", en_cnt, (exp_n == 0) ? 0 : exp_n + PL);
          check("res_count", rv_cnt, exp_n);
          check("res_valid_with_done", res_valid, exp_n != 0);
          check("arr_a_gating", gate_bad, 0);
          check("queues_empty", q_adr.size() + q_w.size() + q_res.size(), 0);
          job_active    = 1'b0;
          job_done_seen = 1'b1;
        end
      end
    end
  end

  task automatic flush();
    q_adr.delete(); q_wrow.delete(); q_w.delete(); q_res.delete();
    job_active = 1'b0;
  endtask

  task automatic launch(input int n, input bit do_skew);
    logic [AW-1:0] a;
    for (int i = 0; i < AS; i++) begin
      q_adr.push_back(AW'(i));
      q_wrow.push_back(2'(i));
      q_w.push_back(mem[i]);
    end
    for (int k = 0; k < n; k++) begin
      a = AW'((AB + k) % 512);
      q_adr.push_back(a);
      q_res.push_back(mvm(mem[a], mem[0], mem[1], mem[2]));
    end
    exp_n = n;
    exp_done = (n == 0) ? 5 : 10 + n;
    busy_cnt = 0; en_cnt = 0; rv_cnt = 0; gate_bad = 0;
    skew_chk = do_skew;
    job_done_seen = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; n_rows = 8'(n);
    job_t0 = ncyc + 1;
    job_active = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; n_rows = 8'($urandom);
  endtask

  // sc > 0: extra start pulse held during cycle sc of the job (must be ignored).
  task automatic run_job(input int n, input int sc, input bit do_skew);
    launch(n, do_skew);
    if (sc > 0) begin
      while (ncyc < job_t0 + sc - 1) @(posedge clk);
      #2; start = 1'b1; n_rows = 8'($urandom);
      @(posedge clk); #2; start = 1'b0;
    end
    for (int t = 0; t < exp_done + 30 && !job_done_seen; t++) @(posedge clk);
    if (!job_done_seen) begin
      check("done_timeout", 0, 1);
      flush();
    end else begin
      #2;
      check("busy_after_done", busy, 0);
    end
    skew_chk = 1'b0;
    repeat ($urandom_range(3, 0)) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d;
    for (int i = 0; i < 512; i++) mem[i] = 24'($urandom);
    #12;
    check("reset_outputs", all_outputs(), 128'd0);
    @(posedge clk); #2; reset_n = 1'b1;
    repeat (4) @(posedge clk);
    check("idle_after_reset", {busy, ram_re, arr_en}, 3'b000);

    mem[16] = 24'h030201; mem[17] = 24'h060504;
    run_job(2, 0, 1'b1);
    run_job(4, 0, 1'b0);
    run_job(4, 6, 1'b0);
    run_job(0, 0, 1'b0);
    run_job(0, 5, 1'b0);
    run_job(1, 11, 1'b0);
    run_job(40, 0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      if (j % 4 == 0) for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
      n = $urandom_range(12, 0);
      d = (n == 0) ? 5 : 10 + n;
      run_job(n, ($urandom_range(1, 0) == 1) ? int'($urandom_range(d, 2)) : 0, 1'b0);
    end

    // Reset asserted in the middle of streaming.
    launch(8, 1'b0);
    while (ncyc < job_t0 + 5) @(posedge clk);
    #2; reset_n = 1'b0;
    #1; check("reset_mid_stream", all_outputs(), 128'd0);
    flush();
    repeat (3) @(posedge clk);
    #2; reset_n = 1'b1;
    repeat (4) @(posedge clk);
    run_job(3, 0, 1'b0);

`ifdef SEQ_ABORT_EN
    launch(4, 1'b0);
    while (ncyc < job_t0 + 5) @(posedge clk);
    #2; abort = 1'b1;
    @(posedge clk); #2; abort = 1'b0;
    flush();
    check("abort_busy", {busy, arr_en}, 2'b00);
    repeat (20) @(posedge clk);
    run_job(5, 0, 1'b0);
`endif

    run_job(6, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
